// File: rtl/sram_port_pkg.sv
// Shared SRAM port definitions: mask granule, mask-width helper and the
// request/response records used at the client side of the RW0 initiator.
package sram_port_pkg;

    localparam int SRAM_GRAN   = 8;
    localparam int REQ_ADDR_W  = 8;
    localparam int REQ_DATA_W  = 32;

    function automatic int mask_width(input int data_w);
        return data_w / SRAM_GRAN;
    endfunction

    typedef struct packed {
        logic                               write;
        logic [REQ_ADDR_W-1:0]              addr;
        logic [REQ_DATA_W/SRAM_GRAN-1:0]    mask;
        logic [REQ_DATA_W-1:0]              wdata;
    } sram_req_t;

    typedef struct packed {
        logic [REQ_DATA_W-1:0]              rdata;
    } sram_resp_t;

endpackage

// File: rtl/sram_resp_queue.sv
// Small circular FIFO holding read responses the client has not yet taken.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sram_resp_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq,
    input  logic [W-1:0]  wdata,
    input  logic          deq,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d    = enq ? wrap_inc(wr_q) : wr_q;
        rd_d    = deq ? wrap_inc(rd_q) : rd_q;
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/sram_rw0_initiator.sv
// Valid/ready front-end for the RW0 port of a byte-masked single-port SRAM.
// Reads return in order; a credit counter guarantees every read has a slot.
module sram_rw0_initiator
    import sram_port_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = mask_width(DATA_W),
    parameter int RESP_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d, q_count;
    logic              rd_inflight_q;
    logic              fire, rd_fire, pop, q_empty, enq, deq;
    logic [DATA_W-1:0] q_head;

    // Credits cover both the read in flight and queued data, so the queue
    // can never be asked to take data while full.
    assign req_ready  = reset_n & (cnt_q < CNT_W'(RESP_DEPTH));
    assign fire       = req_valid & req_ready;
    assign rd_fire    = fire & ~req_write;

    assign sram_en    = fire;
    assign sram_wmode = req_write;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;
    assign sram_wmask = (reset_n & req_write) ? req_mask : '0;

    assign q_empty    = (q_count == '0);
    assign resp_valid = rd_inflight_q | ~q_empty;
    assign resp_rdata = q_empty ? sram_rdata : q_head;
    assign pop        = resp_valid & resp_ready;

    // Inflight data bypasses the queue only when nothing is ahead of it.
    assign enq        = rd_inflight_q & ~(q_empty & resp_ready);
    assign deq        = ~q_empty & resp_ready;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(rd_fire) - CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rd_inflight_q <= rd_fire;
        end
    end

    sram_resp_queue #(
        .DEPTH (RESP_DEPTH),
        .W     (DATA_W),
        .CW    (CNT_W)
    ) u_q (
        .clk   (clock),
        .rst_n (reset_n),
        .enq   (enq),
        .wdata (sram_rdata),
        .deq   (deq),
        .rdata (q_head),
        .count (q_count)
    );

endmodule

// File: tb/tb_sram_rw0_initiator.sv
// Bench for sram_rw0_initiator: macro model with garbage-on-idle rdata and
// an in-order expected-response queue built from a reference memory.
module tb_sram_rw0_initiator;
    import sram_port_pkg::*;

    localparam int RESP_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        sram_en, sram_wmode;
    logic [7:0]  sram_addr;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] exp_q    [$];
    int          vectors = 0, miscompares = 0, resp_seen = 0;
    logic [31:0] last_rdata;

    sram_rw0_initiator #(.ADDR_W(8), .DATA_W(32), .MASK_W(4), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // Macro model: rdata is meaningful only the cycle after a read.
    always @(posedge clock) begin
        if (sram_en && !sram_wmode) sram_rdata <= sram_mem[sram_addr];
        else                        sram_rdata <= $urandom;
        if (sram_en && sram_wmode)
            for (int b = 0; b < 4; b++)
                if (sram_wmask[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input sram_req_t r, input logic v, input logic rr);
        logic exp_ready, exp_fire;
        req_valid = v; req_write = r.write; req_addr = r.addr;
        req_mask = r.mask; req_wdata = r.wdata; resp_ready = rr;
        @(negedge clock);
        exp_ready = (exp_q.size() < RESP_DEPTH);
        exp_fire  = v && exp_ready;
        chk("req_ready", req_ready, exp_ready);
        chk("sram_en", sram_en, exp_fire);
        chk("sram_wmask", sram_wmask, r.write ? r.mask : 4'h0);
        if (exp_fire) begin
            chk("sram_addr", sram_addr, r.addr);
            chk("sram_wmode", sram_wmode, r.write);
        end
        chk("resp_valid", resp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("resp_rdata", resp_rdata, exp_q[0]);
            if (rr) begin
                last_rdata = exp_q.pop_front();
                resp_seen++;
            end
        end
        chk("cnt_bound", dut.cnt_q <= RESP_DEPTH, 1'b1);
        chk("no_enq_full", dut.enq && (dut.q_count == RESP_DEPTH), 1'b0);
        if (exp_fire && r.write) begin
            for (int b = 0; b < 4; b++)
                if (r.mask[b]) ref_mem[r.addr][b*8 +: 8] = r.wdata[b*8 +: 8];
        end else if (exp_fire) begin
            exp_q.push_back(ref_mem[r.addr]);
        end
        @(posedge clock);
        #1;
    endtask

    function automatic sram_req_t mk(input logic w, input logic [7:0] a,
                                     input logic [3:0] m, input logic [31:0] d);
        sram_req_t r;
        r.write = w; r.addr = a; r.mask = m; r.wdata = d;
        return r;
    endfunction

    initial begin
        sram_req_t idle;
        int seen0;
        idle = mk(1'b0, 8'h0, 4'h0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end

        // Reset state with a write presented: nothing may leak to the macro.
        req_valid = 1'b1; req_write = 1'b1; req_mask = 4'hF; resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_wmask", sram_wmask, 4'h0);
        reset_n = 1'b1;

        // 1: full-mask write then read, response two cycles after write fire
        step(mk(1'b1, 8'h10, 4'hF, 32'hDEADBEEF), 1'b1, 1'b1);
        step(mk(1'b0, 8'h10, 4'h0, 32'h0), 1'b1, 1'b1);
        seen0 = resp_seen;
        step(idle, 1'b0, 1'b1);
        chk("t1_latency", resp_seen - seen0, 1);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);

        // 2: partial-mask overwrite
        step(mk(1'b1, 8'h20, 4'hF, 32'hFFFFFFFF), 1'b1, 1'b1);
        step(mk(1'b1, 8'h20, 4'b0101, 32'h00000000), 1'b1, 1'b1);
        step(mk(1'b0, 8'h20, 4'h0, 32'h0), 1'b1, 1'b1);
        step(idle, 1'b0, 1'b1);
        chk("t2_rdata", last_rdata, 32'hFF00FF00);

        // 3: back-to-back reads, full throughput
        seen0 = resp_seen;
        for (int i = 0; i < 8; i++) step(mk(1'b0, 8'(i), 4'h0, 32'h0), 1'b1, 1'b1);
        step(idle, 1'b0, 1'b1);
        chk("t3_resp_count", resp_seen - seen0, 8);

        // 4: backpressure fills the credits, then drains in order
        for (int i = 0; i < 4; i++) step(mk(1'b0, 8'(8'h30 + i), 4'h0, 32'h0), 1'b1, 1'b0);
        chk("t4_cnt_full", dut.cnt_q, RESP_DEPTH);
        step(mk(1'b1, 8'h40, 4'hF, 32'h12345678), 1'b1, 1'b0);
        seen0 = resp_seen;
        step(idle, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b1);
        chk("t4_drained", resp_seen - seen0, 2);
        step(idle, 1'b0, 1'b1);

        // 5: reset the cycle after a read fire discards the read
        step(mk(1'b0, 8'h10, 4'h0, 32'h0), 1'b1, 1'b1);
        req_valid = 1'b0; reset_n = 1'b0;
        #1;
        chk("t5_resp_killed", resp_valid, 1'b0);
        chk("t5_ready_in_rst", req_ready, 1'b0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(idle, 1'b0, 1'b1);
        step(idle, 1'b0, 1'b1);

        // 6: random mixed traffic with random backpressure
        for (int i = 0; i < 10000; i++)
            step(mk(1'($urandom), 8'($urandom), 4'($urandom), $urandom),
                 1'($urandom), ($urandom % 4) != 0);
        for (int i = 0; i < 4; i++) step(idle, 1'b0, 1'b1);
        chk("t6_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
